// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, accumulator state encoding and saturation limits.
package mult_pkg;
    localparam int PROD_W_D = 9;
    localparam int ACC_W_D  = 10;
    localparam logic signed [ACC_W_D:0] SAT_MAX = {2'b00, {(ACC_W_D-1){1'b1}}};
    localparam logic signed [ACC_W_D:0] SAT_MIN = {2'b11, {(ACC_W_D-1){1'b0}}};
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/mult_dot_accum_if.sv
// mult_dot_accum_if: product/done bus from the multiplier to the accumulator.
interface mult_dot_accum_if #(parameter int PROD_W = 9);
    logic [PROD_W-1:0] Prod;
    logic              done;
    modport master(output Prod, done);
    modport slave(input Prod, done);
endinterface

// File: rtl/rise_edge_det.sv
// rise_edge_det: one-cycle pulse on a rising input; delay register resets high so a level held through reset is ignored.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic q;
    always_ff @(posedge clk) q <= rst ? 1'b1 : in;
    assign pulse = in & ~q;
endmodule

// File: rtl/mult_dot_accum.sv
// mult_dot_accum: accumulates N_TERMS signed products, one per done rising edge, into a saturating sum.
module mult_dot_accum
    import mult_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int PROD_W  = PROD_W_D,
    parameter int ACC_W   = ACC_W_D,
    parameter int CNT_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    mult_dot_accum_if.slave         bus,
    output logic signed [ACC_W-1:0] Sum,
    output logic [CNT_W-1:0]        term_cnt,
    output logic                    sum_valid,
    output logic                    ovf
);
    localparam logic signed [ACC_W:0] MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN = {2'b11, {(ACC_W-1){1'b0}}};
    state_t state, state_n;
    logic accept, load, hit_hi, hit_lo, valid_n, ovf_n;
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W-1:0] sum_n;
    logic [CNT_W-1:0] cnt_n;
    rise_edge_det u_edge (.clk(clk), .rst(rst), .in(bus.done), .pulse(accept));
    // clr or a non-ACCUM state loads the product as term 1 instead of adding
    assign load   = clr || state != ACCUM;
    assign wide   = (load ? '0 : {Sum[ACC_W-1], Sum}) + {{(ACC_W+1-PROD_W){bus.Prod[PROD_W-1]}}, bus.Prod};
    assign hit_hi = wide > MAX;
    assign hit_lo = wide < MIN;
    always_comb begin
        state_n = state;
        sum_n   = Sum;
        cnt_n   = term_cnt;
        valid_n = sum_valid;
        ovf_n   = ovf;
        if (clr) begin
            state_n = IDLE;
            sum_n   = '0;
            cnt_n   = '0;
            valid_n = 1'b0;
            ovf_n   = 1'b0;
        end
        if (accept) begin
            sum_n   = hit_hi ? MAX[ACC_W-1:0] : hit_lo ? MIN[ACC_W-1:0] : wide[ACC_W-1:0];
            cnt_n   = load ? CNT_W'(1) : term_cnt + CNT_W'(1);
            ovf_n   = (!load && ovf) || hit_hi || hit_lo;
            valid_n = cnt_n == CNT_W'(N_TERMS);
            state_n = valid_n ? HOLD : ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Sum       <= '0;
            term_cnt  <= '0;
            sum_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            Sum       <= sum_n;
            term_cnt  <= cnt_n;
            sum_valid <= valid_n;
            ovf       <= ovf_n;
        end
    end
endmodule
